// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer for a req/ack instruction memory: one request per PC, best case 2 cycles/instr.
// Stalls PC while a fetch is outstanding; ext_stall holds DELIVER. FETCH_TIMEOUT_EN adds a wait timeout into HALT.
module fetch_sequencer #(
  parameter logic [31:0] NOP_INSTR      = 32'h00000013,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        redirect,
  input  logic        ext_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        flush_d,
  output logic        fetch_err
);

  localparam logic [2:0] ISSUE   = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] DELIVER = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [31:0] instrQ;
  logic [31:0] addrQ;
  logic        ownStall;
  logic        reqPhase;
  logic        halted;
  logic        capture;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] waitCnt;
  logic       fetchErrQ;
  logic       timeoutHit;

  // Counter holds the number of ack-less WAIT/DRAIN cycles already spent.
  assign timeoutHit = ((state == WAIT) || (state == DRAIN)) && !mem_ack &&
                      (waitCnt == 8'(TIMEOUT_CYCLES - 1));
  assign halted     = (state == HALT);
  assign fetch_err  = fetchErrQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt   <= 8'd0;
      fetchErrQ <= 1'b0;
    end else begin
      if (stateNext == ISSUE) begin
        waitCnt <= 8'd0;
      end else if (((state == WAIT) || (state == DRAIN)) && !mem_ack) begin
        waitCnt <= waitCnt + 8'd1;
      end
      if (stateNext == HALT) begin
        fetchErrQ <= 1'b1;
      end
    end
  end
`else
  assign halted    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      ISSUE: begin
        if (mem_ack) stateNext = redirect ? ISSUE : DELIVER;
        else         stateNext = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (mem_ack)       stateNext = redirect ? ISSUE : DELIVER;
        else if (redirect) stateNext = DRAIN;
      end
      DELIVER: begin
        if (redirect || !ext_stall) stateNext = ISSUE;
      end
      DRAIN: begin
        // The in-flight word is stale; the protocol still requires waiting for its ack.
        if (mem_ack) stateNext = ISSUE;
      end
`ifdef FETCH_TIMEOUT_EN
      HALT:    stateNext = HALT;
`endif
      default: stateNext = ISSUE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (timeoutHit) stateNext = HALT;
`endif
  end

  assign capture = ((state == ISSUE) || (state == WAIT)) && mem_ack && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ISSUE;
      instrQ <= NOP_INSTR;
      addrQ  <= 32'd0;
    end else begin
      state <= stateNext;
      if (state == ISSUE) addrQ  <= pc_cur;
      if (capture)        instrQ <= mem_rdata;
    end
  end

  assign reqPhase    = (state == ISSUE) || (state == WAIT) || (state == DRAIN);
  assign ownStall    = (state != DELIVER);
  assign mem_req     = reqPhase && !rst;
  assign mem_addr    = (state == ISSUE) ? pc_cur : addrQ;
  assign instr       = (state == DELIVER) ? instrQ : NOP_INSTR;
  assign instr_valid = (state == DELIVER) && !redirect;
  // Reset and HALT force the PC and F/D register to hold a bubble regardless of redirect.
  assign fetch_stall = rst || halted || ((ownStall || ext_stall) && !redirect);
  assign flush_d     = rst || halted || redirect || (ownStall && !ext_stall);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        redirect;
  logic        ext_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_stall;
  logic        flush_d;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Reference model: a held word awaiting delivery, a latched in-flight address, a stale flag.
  bit          mHold;
  bit          mLatched;
  bit          mStale;
  logic [31:0] mWord;
  logic [31:0] mAddr;

  fetch_sequencer #(.NOP_INSTR(NOP), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .redirect(redirect), .ext_stall(ext_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .fetch_stall(fetch_stall), .flush_d(flush_d),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mHold = 0; mLatched = 0; mStale = 0; mWord = NOP; mAddr = 32'd0;
  endtask

  task automatic setIn(input logic rd, input logic es, input logic ak,
                       input logic [31:0] rdat, input logic [31:0] pc);
    redirect = rd; ext_stall = es; mem_ack = ak; mem_rdata = rdat; pc_cur = pc;
  endtask

  // Drive one cycle's inputs and compare every output against the model.
  task automatic cyc(input logic rd, input logic es, input logic ak,
                     input logic [31:0] rdat, input logic [31:0] pc);
    logic own;
    setIn(rd, es, ak, rdat, pc);
    #1;
    own = !mHold;
    chk("mem_req", 32'(mem_req), 32'(own));
    if (own) chk("mem_addr", mem_addr, mLatched ? mAddr : pc);
    chk("instr", instr, mHold ? mWord : NOP);
    chk("instr_valid", 32'(instr_valid), 32'(mHold && !rd));
    chk("fetch_stall", 32'(fetch_stall), 32'((own || es) && !rd));
    chk("flush_d", 32'(flush_d), 32'(rd || (own && !es)));
    chk("fetch_err", 32'(fetch_err), 32'd0);
  endtask

  task automatic adv();
    if (mHold) begin
      if (redirect || !ext_stall) mHold = 0;
    end else if (mem_ack) begin
      if (!mStale && !redirect) begin
        mHold = 1;
        mWord = mem_rdata;
      end
      mLatched = 0;
      mStale   = 0;
    end else begin
      if (!mLatched) mAddr = pc_cur;
      mLatched = 1;
      mStale   = mStale || redirect;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int reqHigh;
    int stallLow;
    int noAckRun;
    logic rd, es, ak;

    rst = 1'b1;
    setIn(0, 0, 0, 32'd0, 32'd0);
    modelReset();
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
    chk("rst_flush_d", 32'(flush_d), 32'd1);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;

    // Zero-wait memory: ISSUE then DELIVER, back-to-back.
    cyc(0, 0, 1, 32'hAAAA0001, 32'h0);
    chk("zw_addr0", mem_addr, 32'h0);
    chk("zw_flush_issue", 32'(flush_d), 32'd1);
    adv();
    cyc(0, 0, 0, 32'h0, 32'h4);
    chk("zw_instr0", instr, 32'hAAAA0001);
    chk("zw_valid0", 32'(instr_valid), 32'd1);
    chk("zw_flush_deliver", 32'(flush_d), 32'd0);
    adv();
    cyc(0, 0, 1, 32'hAAAA0002, 32'h4);
    chk("zw_addr1", mem_addr, 32'h4);
    adv();
    cyc(0, 0, 0, 32'h0, 32'h8);
    chk("zw_instr1", instr, 32'hAAAA0002);
    adv();

    // Three-wait memory at 0x100.
    reqHigh = 0; stallLow = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, (i == 3), 32'h00500093, (i < 4) ? 32'h100 : 32'h104);
      if (mem_req && mem_addr == 32'h100) reqHigh++;
      if (!fetch_stall) stallLow++;
      if (i == 4) chk("w3_instr", instr, 32'h00500093);
      adv();
    end
    chk("w3_req_cycles", 32'(reqHigh), 32'd4);
    chk("w3_stall_low", 32'(stallLow), 32'd1);

`ifndef FETCH_TIMEOUT_EN
    // Redirect in the second WAIT cycle of a 5-wait access; stale word drained.
    cyc(0, 0, 0, 32'h0, 32'h20); adv();
    cyc(0, 0, 0, 32'h0, 32'h20); adv();
    cyc(1, 0, 0, 32'h0, 32'h20);
    chk("rdr_fetch_stall", 32'(fetch_stall), 32'd0);
    chk("rdr_flush_d", 32'(flush_d), 32'd1);
    adv();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, (i == 3), 32'hDEADBEEF, 32'h80);
      chk("drain_addr", mem_addr, 32'h20);
      chk("drain_valid", 32'(instr_valid), 32'd0);
      adv();
    end
    cyc(0, 0, 1, 32'h11111111, 32'h80);
    chk("rdr_new_addr", mem_addr, 32'h80);
    adv();
    cyc(0, 0, 0, 32'h0, 32'h84);
    chk("rdr_new_instr", instr, 32'h11111111);
    adv();
`endif

    // ext_stall held for 3 cycles during DELIVER.
    cyc(0, 0, 1, 32'h22222222, 32'h200); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 32'h0, 32'h200);
      chk("es_instr", instr, 32'h22222222);
      chk("es_fetch_stall", 32'(fetch_stall), 32'd1);
      chk("es_flush_d", 32'(flush_d), 32'd0);
      adv();
    end
    cyc(0, 0, 0, 32'h0, 32'h200);
    chk("es_release_stall", 32'(fetch_stall), 32'd0);
    adv();
    cyc(0, 0, 0, 32'h0, 32'h204);
    chk("es_next_addr", mem_addr, 32'h204);
    adv();

    // Async reset mid-WAIT.
    cyc(0, 0, 0, 32'h0, 32'h204); adv();
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_instr", instr, NOP);
    chk("arst_fetch_stall", 32'(fetch_stall), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    modelReset();
    cyc(0, 0, 0, 32'h0, 32'h340);
    chk("arst_new_addr", mem_addr, 32'h340);
    adv();

    // Randomized traffic; runs of ack-less request cycles are capped.
    noAckRun = 0;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 7) == 0);
      es = ($urandom_range(0, 3) == 0);
      ak = ($urandom_range(0, 2) == 0) || (noAckRun >= 3);
      cyc(rd, es, ak, $urandom(), {$urandom_range(0, 32'h3FFF), 2'b00});
      if (!mHold && !ak) noAckRun++;
      else noAckRun = 0;
      adv();
    end

`ifdef FETCH_TIMEOUT_EN
    // Never-acked request: 4 WAIT cycles then HALT until reset.
    rst = 1'b1; #1; rst = 1'b0; modelReset();
    setIn(0, 0, 0, 32'h0, 32'h400);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_req_high", 32'(mem_req), 32'd1);
      @(posedge clk); #2;
    end
    for (int i = 0; i < 4; i++) begin
      setIn((i == 2), 0, (i == 3), 32'h0, 32'h400);
      #1;
      chk("to_req_low", 32'(mem_req), 32'd0);
      chk("to_err", 32'(fetch_err), 32'd1);
      chk("to_stall", 32'(fetch_stall), 32'd1);
      chk("to_flush", 32'(flush_d), 32'd1);
      @(posedge clk); #2;
    end
    rst = 1'b1; #1;
    chk("to_err_cleared", 32'(fetch_err), 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the fetch stage when instruction memory is multi-cycle with a req/ack handshake. It issues one fetch per PC value and holds the PC and fetch-stage stall while an access is outstanding. It delivers the returned word for exactly one advancing cycle. It handles taken-branch redirects mid-access by draining and discarding the stale response. It sits between the PC/PC-mux/fetch-decode register datapath, the hazard unit, and the instruction memory port.

Parameters:
NOP_INSTR, 32'h00000013, word driven on instr when no valid instruction is delivered (addi x0,x0,0).
TIMEOUT_CYCLES, 64, wait-cycle limit, used only with FETCH_TIMEOUT_EN; 8-bit counter; legal range 1..255.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
pc_cur  in  32  current PC register value; becomes the fetch address.
redirect  in  1  taken branch/jump from execute (pcSrcE); PC mux selects the target this cycle.
ext_stall  in  1  hazard-unit fetch stall request.
mem_req  out  1  instruction memory request; held until mem_ack.
mem_addr  out  32  request address; stable while mem_req=1.
mem_ack  in  1  memory response strobe; mem_rdata valid in the same cycle.
mem_rdata  in  32  returned instruction word.
instr  out  32  instruction to the fetch-decode register (instrF).
instr_valid  out  1  instr holds a delivered instruction this cycle.
fetch_stall  out  1  drives the PC register stall (StallF).
flush_d  out  1  drives the fetch-decode register flush (FlushD), OR'd with the hazard flush outside this block.
fetch_err  out  1  sticky timeout error; always 0 without FETCH_TIMEOUT_EN.

Behaviour:
- States: ISSUE, WAIT, DELIVER, DRAIN (plus HALT with FETCH_TIMEOUT_EN). Reset state is ISSUE.
- Reset (async): state=ISSUE, instr_q=NOP_INSTR, addr_q=0, counter=0, fetch_err=0. Outputs during reset: mem_req=0, instr=NOP_INSTR, instr_valid=0, fetch_stall=1, flush_d=1.
- own_stall = (state != DELIVER).
- fetch_stall = (own_stall | ext_stall) & ~redirect.
- flush_d = redirect | (own_stall & ~ext_stall).
- instr = instr_q when state=DELIVER, else NOP_INSTR. instr_valid = (state=DELIVER) & ~redirect.
- ISSUE: mem_req=1, mem_addr=pc_cur; addr_q<=pc_cur.
  - mem_ack & ~redirect: instr_q<=mem_rdata, go to DELIVER (1-cycle best case).
  - mem_ack & redirect: discard the word, stay in ISSUE.
  - no ack & redirect: go to DRAIN.
  - no ack, no redirect: go to WAIT.
- WAIT: mem_req=1, mem_addr=addr_q.
  - mem_ack & ~redirect: capture the word, go to DELIVER.
  - mem_ack & redirect: go to ISSUE.
  - no ack & redirect: go to DRAIN.
- DELIVER: mem_req=0.
  - redirect: the word is flushed, PC loads the target, go to ISSUE.
  - ext_stall: hold DELIVER with instr_q stable.
  - otherwise: PC advances, F/D register loads instr, go to ISSUE.
- DRAIN: mem_req=1, mem_addr=addr_q. The memory protocol forbids dropping req before ack.
  - mem_ack: discard the word, go to ISSUE.
  - A further redirect in DRAIN still lets the PC load the new target (fetch_stall=0); stay in DRAIN.
- Priority: redirect > ext_stall > own progress.
- mem_ack while mem_req=0 is ignored.
- Throughput: at best one instruction per 2 cycles (ISSUE + DELIVER).

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to ISSUE and increments each WAIT/DRAIN cycle without ack. When it reaches TIMEOUT_CYCLES, mem_req drops, fetch_err sets and stays set, and the block enters HALT. HALT holds fetch_stall=1 and flush_d=1 until reset.
- Undefined: no counter, no HALT state, fetch_err tied to 0, and WAIT/DRAIN wait indefinitely.

Test Plan:
- Zero-wait memory (ack in the request cycle), pc_cur=0x0 then 0x4 -> mem_addr=0x0, then instr=word0 with instr_valid=1 in cycle 2, mem_addr=0x4 in cycle 3; flush_d=1 only in ISSUE cycles.
- 3-wait memory, pc_cur=0x100, rdata=0x00500093 -> mem_req high 4 cycles with mem_addr=0x100; DELIVER presents 0x00500093 once; fetch_stall low exactly one cycle.
- Redirect in WAIT cycle 2 of a 5-wait access at 0x20, target 0x80 -> fetch_stall=0 and flush_d=1 that cycle; DRAIN holds mem_addr=0x20 until ack; word discarded (instr_valid stays 0); next request at 0x80.
- ext_stall=1 for 3 cycles during DELIVER -> instr stable, fetch_stall=1, flush_d=0; advances the cycle after ext_stall falls.
- Async rst asserted mid-WAIT -> mem_req=0 and instr=0x00000013 immediately without a clock edge; after release, a new request at the current pc_cur.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4, ack never returned -> mem_req drops after 4 wait cycles, fetch_err=1 and held, fetch_stall=1 permanently until rst.
